pmem_ram_lat: RTL and testbench

- Parametrised program memory for the BX core fetch path; successor to the fixed 256x32, 1-cycle instruction ROM.
- Adds:
  - configurable width, depth and read latency (1 or 2);
  - a word-write load port for boot-time program download;
  - a post-reset clear sequencer that fills memory with NOP;
  - fault flagging for misaligned or out-of-range fetches.
- Sits between the core PC stage and the instruction register. The loader (debug/UART) drives the load port.

---
 rtl/pmem_ram_lat_if.sv | 31 +++
 rtl/pmem_ram_lat.sv | 154 +++++++++++++++
 tb/tb_pmem_ram_lat.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pmem_ram_lat_if.sv
// Fetch and load port bundle for pmem_ram_lat.
// The core/loader side uses the master modport and the memory uses the slave modport.
interface pmem_ram_lat_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              fetch_req_c0;
  logic [ADDR_W-1:0] pc_read_c0;
  logic              fetch_gnt_c0;
  logic              instr_vld_cl;
  logic [DATA_W-1:0] instr_reg_cl;
  logic              instr_fault_cl;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
  logic              ld_err;
  logic              init_busy;

  modport master (
    output fetch_req_c0, pc_read_c0, ld_we, ld_addr, ld_data,
    input  fetch_gnt_c0, instr_vld_cl, instr_reg_cl, instr_fault_cl,
           ld_ack, ld_err, init_busy
  );

  modport slave (
    input  fetch_req_c0, pc_read_c0, ld_we, ld_addr, ld_data,
    output fetch_gnt_c0, instr_vld_cl, instr_reg_cl, instr_fault_cl,
           ld_ack, ld_err, init_busy
  );
endinterface

// File: rtl/pmem_ram_lat.sv
// Program memory for the fetch path: the fetch latency is 1 or 2 cycles, and a word-write load port is provided.
// After reset, a clear sequencer fills the array with FILL, and faults are flagged on bad fetch addresses.
module pmem_ram_lat #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DEPTH    = 256,
  parameter int unsigned       LAT      = 1,
  parameter logic [DATA_W-1:0] FILL     = DATA_W'(32'h0000_0013),
  parameter bit                INIT_CLR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  pmem_ram_lat_if.slave   bus
);
  localparam int unsigned      IDX_W    = ADDR_W - 2;
  localparam int unsigned      CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(DEPTH - 1);

  if ((LAT != 1) && (LAT != 2)) begin : g_bad_lat
    $error("pmem_ram_lat: LAT must be 1 or 2");
  end
  if (DEPTH > (32'd1 << IDX_W)) begin : g_bad_depth
    $error("pmem_ram_lat: DEPTH exceeds the word-addressable range");
  end

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  localparam state_t ST_RST = state_t'(~INIT_CLR);

  logic [DATA_W-1:0] mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              init_busy_q;
  logic              mem_we_s;
  logic [CNT_W-1:0]  mem_widx_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              gnt_s, pc_legal_s, ld_legal_s;
  logic [IDX_W-1:0]  pc_idx_s, ld_idx_s;
  logic              vld1_q, fault1_q, ld_ack_q, ld_err_q;
  logic [DATA_W-1:0] data1_q;

  assign pc_idx_s   = bus.pc_read_c0[ADDR_W-1:2];
  assign ld_idx_s   = bus.ld_addr[ADDR_W-1:2];
  assign pc_legal_s = (bus.pc_read_c0[1:0] == 2'b00) && (32'(pc_idx_s) < DEPTH);
  assign ld_legal_s = (bus.ld_addr[1:0] == 2'b00) && (32'(ld_idx_s) < DEPTH);

  // The clear sequencer owns the array write port in INIT; in RUN the load port owns it and also blocks fetch grants.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we_s    = 1'b0;
    mem_widx_s  = clr_cnt_q;
    mem_wdata_s = FILL;
    gnt_s       = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we_s = 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_W'(1'b1);
        end
      end
      ST_RUN: begin
        gnt_s = bus.fetch_req_c0 & ~bus.ld_we;
        if (bus.ld_we && ld_legal_s) begin
          mem_we_s    = 1'b1;
          mem_widx_s  = ld_idx_s[CNT_W-1:0];
          mem_wdata_s = bus.ld_data;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_d   = ST_RST;
        clr_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RST;
      clr_cnt_q   <= {CNT_W{1'b0}};
      init_busy_q <= INIT_CLR;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_busy_q <= (state_d == ST_INIT);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_widx_s] <= mem_wdata_s;
    end
  end

  // A faulting fetch never touches the array; it returns FILL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_q   <= 1'b0;
      fault1_q <= 1'b0;
      data1_q  <= {DATA_W{1'b0}};
    end else begin
      vld1_q   <= gnt_s;
      fault1_q <= gnt_s & ~pc_legal_s;
      if (gnt_s) begin
        data1_q <= pc_legal_s ? mem_q[pc_idx_s[CNT_W-1:0]] : FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ack_q <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      ld_ack_q <= (state_q == ST_RUN) & bus.ld_we;
      ld_err_q <= (state_q == ST_RUN) & bus.ld_we & ~ld_legal_s;
    end
  end

  if (LAT == 2) begin : g_lat2
    logic              vld2_q, fault2_q;
    logic [DATA_W-1:0] data2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld2_q   <= 1'b0;
        fault2_q <= 1'b0;
        data2_q  <= {DATA_W{1'b0}};
      end else begin
        vld2_q   <= vld1_q;
        fault2_q <= vld1_q & fault1_q;
        if (vld1_q) begin
          data2_q <= data1_q;
        end
      end
    end

    assign bus.instr_vld_cl   = vld2_q;
    assign bus.instr_fault_cl = fault2_q;
    assign bus.instr_reg_cl   = data2_q;
  end else begin : g_lat1
    assign bus.instr_vld_cl   = vld1_q;
    assign bus.instr_fault_cl = fault1_q;
    assign bus.instr_reg_cl   = data1_q;
  end

  assign bus.fetch_gnt_c0 = gnt_s;
  assign bus.ld_ack       = ld_ack_q;
  assign bus.ld_err       = ld_err_q;
  assign bus.init_busy    = init_busy_q;
endmodule

// File: tb/tb_pmem_ram_lat.sv
// Scoreboard bench for pmem_ram_lat: instance A is 256 words with latency 1, and instance B is 200 words with latency 2.
// Both instances share the same stimulus, and each has its own reference model and response queues.
module tb_pmem_ram_lat;
  localparam logic [31:0] FILL_W = 32'h0000_0013;
  localparam int DEP_A = 256, DEP_B = 200, LAT_A = 1, LAT_B = 2;

  typedef struct { logic [31:0] data; logic fault; int due; } fexp_t;
  typedef struct { logic err; int due; } lexp_t;

  logic clk, rst;
  logic req, we;
  logic [9:0] pc, la;
  logic [31:0] ld;
  int cyc = 0, rel_cyc = 0;
  bit in_rst = 1'b1;
  int errors = 0, checks = 0;

  logic [31:0] ma [DEP_A];
  logic [31:0] mb [DEP_B];
  fexp_t qa[$], qb[$];
  lexp_t lqa[$], lqb[$];

  pmem_ram_lat_if #(.ADDR_W(10), .DATA_W(32)) bus_a ();
  pmem_ram_lat_if #(.ADDR_W(10), .DATA_W(32)) bus_b ();

  pmem_ram_lat #(.DEPTH(DEP_A), .LAT(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pmem_ram_lat #(.DEPTH(DEP_B), .LAT(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.fetch_req_c0 = req;  assign bus_b.fetch_req_c0 = req;
  assign bus_a.pc_read_c0   = pc;   assign bus_b.pc_read_c0   = pc;
  assign bus_a.ld_we        = we;   assign bus_b.ld_we        = we;
  assign bus_a.ld_addr      = la;   assign bus_b.ld_addr      = la;
  assign bus_a.ld_data      = ld;   assign bus_b.ld_data      = ld;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [9:0] a, input int depth);
    return (a % 4 == 0) && (int'(a / 4) < depth);
  endfunction

  function automatic logic [9:0] pick_addr();
    logic [9:0] a;
    if ($urandom_range(0, 3) == 0) a = 10'($urandom_range(0, 1023));
    else a = 10'h300 + 10'(4 * $urandom_range(0, 15)) + 10'($urandom_range(0, 7) == 0 ? 1 : 0);
    return a;
  endfunction

  task automatic release_rst();
    rst = 1'b0; in_rst = 1'b0; rel_cyc = cyc;
    foreach (ma[i]) ma[i] = FILL_W;
    foreach (mb[i]) mb[i] = FILL_W;
  endtask

  // The model's rule: each instance leaves INIT exactly DEPTH cycles after reset is released.
  task automatic step(input logic r, input logic [9:0] p, input logic w, input logic [9:0] a, input logic [31:0] d);
    bit run_a, run_b;
    req = r; pc = p; we = w; la = a; ld = d;
    #1;
    run_a = !in_rst && (cyc >= rel_cyc + DEP_A);
    run_b = !in_rst && (cyc >= rel_cyc + DEP_B);
    chk("gnt_a", bus_a.fetch_gnt_c0, run_a && r && !w);
    chk("gnt_b", bus_b.fetch_gnt_c0, run_b && r && !w);
    chk("busy_a", bus_a.init_busy, !run_a);
    chk("busy_b", bus_b.init_busy, !run_b);
    if (run_a && r && !w)
      qa.push_back('{legal(p, DEP_A) ? ma[p / 4] : FILL_W, !legal(p, DEP_A), cyc + LAT_A});
    if (run_b && r && !w)
      qb.push_back('{legal(p, DEP_B) ? mb[p / 4] : FILL_W, !legal(p, DEP_B), cyc + LAT_B});
    if (run_a && w) begin
      lqa.push_back('{!legal(a, DEP_A), cyc + 1});
      if (legal(a, DEP_A)) ma[a / 4] = d;
    end
    if (run_b && w) begin
      lqb.push_back('{!legal(a, DEP_B), cyc + 1});
      if (legal(a, DEP_B)) mb[a / 4] = d;
    end
    @(posedge clk); #1;
  endtask

  task automatic rnd_step();
    step(1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 3) == 0), pick_addr(), $urandom());
  endtask

  always @(negedge clk) begin : mon_a
    fexp_t e; lexp_t l;
    if (bus_a.instr_vld_cl) begin
      if (qa.size() == 0) chk("a_unexpected_vld", bus_a.instr_vld_cl, 1'b0);
      else begin
        e = qa.pop_front();
        chk("a_vld_cycle", 32'(cyc), 32'(e.due));
        chk("a_data", bus_a.instr_reg_cl, e.data);
        chk("a_fault", bus_a.instr_fault_cl, e.fault);
      end
    end else begin
      if (bus_a.instr_fault_cl) chk("a_fault_idle", bus_a.instr_fault_cl, 1'b0);
      if (qa.size() > 0 && qa[0].due <= cyc) begin
        chk("a_missing_vld", bus_a.instr_vld_cl, 1'b1);
        void'(qa.pop_front());
      end
    end
    if (bus_a.ld_ack) begin
      if (lqa.size() == 0) chk("a_unexpected_ack", bus_a.ld_ack, 1'b0);
      else begin
        l = lqa.pop_front();
        chk("a_ack_cycle", 32'(cyc), 32'(l.due));
        chk("a_ld_err", bus_a.ld_err, l.err);
      end
    end else if (lqa.size() > 0 && lqa[0].due <= cyc) begin
      chk("a_missing_ack", bus_a.ld_ack, 1'b1);
      void'(lqa.pop_front());
    end
  end

  always @(negedge clk) begin : mon_b
    fexp_t e; lexp_t l;
    if (bus_b.instr_vld_cl) begin
      if (qb.size() == 0) chk("b_unexpected_vld", bus_b.instr_vld_cl, 1'b0);
      else begin
        e = qb.pop_front();
        chk("b_vld_cycle", 32'(cyc), 32'(e.due));
        chk("b_data", bus_b.instr_reg_cl, e.data);
        chk("b_fault", bus_b.instr_fault_cl, e.fault);
      end
    end else begin
      if (bus_b.instr_fault_cl) chk("b_fault_idle", bus_b.instr_fault_cl, 1'b0);
      if (qb.size() > 0 && qb[0].due <= cyc) begin
        chk("b_missing_vld", bus_b.instr_vld_cl, 1'b1);
        void'(qb.pop_front());
      end
    end
    if (bus_b.ld_ack) begin
      if (lqb.size() == 0) chk("b_unexpected_ack", bus_b.ld_ack, 1'b0);
      else begin
        l = lqb.pop_front();
        chk("b_ack_cycle", 32'(cyc), 32'(l.due));
        chk("b_ld_err", bus_b.ld_err, l.err);
      end
    end else if (lqb.size() > 0 && lqb[0].due <= cyc) begin
      chk("b_missing_ack", bus_b.ld_ack, 1'b1);
      void'(lqb.pop_front());
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; pc = 10'h000; la = 10'h000; ld = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld_a", bus_a.instr_vld_cl, 1'b0);     chk("rst_vld_b", bus_b.instr_vld_cl, 1'b0);
    chk("rst_reg_a", bus_a.instr_reg_cl, 32'h0);    chk("rst_reg_b", bus_b.instr_reg_cl, 32'h0);
    chk("rst_fault_a", bus_a.instr_fault_cl, 1'b0); chk("rst_fault_b", bus_b.instr_fault_cl, 1'b0);
    chk("rst_ack_a", bus_a.ld_ack, 1'b0);           chk("rst_ack_b", bus_b.ld_ack, 1'b0);
    chk("rst_err_a", bus_a.ld_err, 1'b0);           chk("rst_err_b", bus_b.ld_err, 1'b0);
    chk("rst_busy_a", bus_a.init_busy, 1'b1);       chk("rst_busy_b", bus_b.init_busy, 1'b1);

    release_rst();
    repeat (100) rnd_step();
    rst = 1'b1; in_rst = 1'b1;
    qa.delete(); qb.delete(); lqa.delete(); lqb.delete();
    #1;
    chk("midrst_busy_a", bus_a.init_busy, 1'b1);
    chk("midrst_vld_b", bus_b.instr_vld_cl, 1'b0);
    repeat (3) rnd_step();

    release_rst();
    repeat (DEP_A) rnd_step();

    step(1'b1, 10'h3FC, 1'b0, 10'h000, 32'h0);
    step(1'b0, 10'h000, 1'b1, 10'h074, 32'hFF01_0113);
    step(1'b1, 10'h074, 1'b0, 10'h000, 32'h0);
    step(1'b1, 10'h080, 1'b1, 10'h080, 32'hA5A5_0001);
    step(1'b1, 10'h080, 1'b0, 10'h000, 32'h0);
    step(1'b1, 10'h002, 1'b0, 10'h000, 32'h0);
    step(1'b1, 10'h320, 1'b0, 10'h000, 32'h0);
    step(1'b0, 10'h000, 1'b1, 10'h321, 32'hDEAD_BEEF);
    step(1'b1, 10'h320, 1'b0, 10'h000, 32'h0);
    step(1'b1, 10'h000, 1'b0, 10'h000, 32'h0);
    step(1'b1, 10'h004, 1'b0, 10'h000, 32'h0);
    step(1'b1, 10'h008, 1'b0, 10'h000, 32'h0);
    repeat (3) step(1'b0, 10'h000, 1'b0, 10'h000, 32'h0);

    repeat (600) rnd_step();
    repeat (5) step(1'b0, 10'h000, 1'b0, 10'h000, 32'h0);
    chk("drain_qa", 32'(qa.size()), 32'd0);
    chk("drain_qb", 32'(qb.size()), 32'd0);
    chk("drain_lqa", 32'(lqa.size()), 32'd0);
    chk("drain_lqb", 32'(lqb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
